ram_fifo_ctrl: RTL and testbench

- Single-port-RAM FIFO controller placed directly upstream of the 32 x 1024-bit synchronous RAM (ports clk, data_in, address, write_en, data_out).
- Converts a valid/ready push stream and a valid/ready pop stream into one RAM access per cycle, arbitrating write against read.
- Owns the wrap-around pointers and occupancy, and buffers RAM read data in a 2-entry output skid.

---
 rtl/ram_fifo_pkg.sv | 15 +
 rtl/ram_fifo_skid.sv | 62 ++++++
 rtl/ram_fifo_ctrl.sv | 99 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared constants and types for the single-port-RAM FIFO controller.
package ram_fifo_pkg;

    localparam int DEF_DATA_W = 1024;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 32;
    localparam int SKID_DEPTH = 2;

    // Round-robin arbitration owner of the single RAM port.
    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } rr_t;

endpackage

// File: rtl/ram_fifo_skid.sv
// 2-entry in-order output buffer fed by RAM read data. Entry e0 is the head.
// The controller never captures while the buffer is full.
module ram_fifo_skid
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [DATA_W-1:0] capture_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] e0;
    logic [DATA_W-1:0] e1;
    logic [1:0]        cnt;
    logic              pop_eff;

    // A pop only counts when the head actually holds a word.
    always_comb begin
        pop_eff = pop && (cnt != 2'd0);
    end

    // Shift-style storage: pops move e1 into e0, captures land at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else begin
            case ({capture, pop_eff})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= capture_data;
                    else             e1 <= capture_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        e0 <= capture_data;
                    end else begin
                        e0 <= e1;
                        e1 <= capture_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data  = e0;
    assign head_valid = (cnt != 2'd0);
    assign count      = cnt;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port synchronous RAM. One RAM access
// per cycle, writes and reads alternate under contention, read data lands in
// a 2-entry skid buffer one cycle after the read address is presented.
// Handshakes: a word moves on a rising edge where valid and ready are both 1;
// push_ready depends on controller state only, never on push_valid.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic [ADDR_W+1:0] level,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write_en,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic              rd_inflight;
    logic [DATA_W-1:0] data_hold;
    rr_t               rr;
    rr_t               rr_next;
    logic [1:0]        skid_cnt;
    logic [2:0]        pending;
    logic              rd_elig;
    logic              rd_go;
    logic              wr_go;

    // Arbitration, next owner and RAM port drive.
    always_comb begin
        pending      = {1'b0, skid_cnt} + {2'b00, rd_inflight};
        rd_elig      = (ram_cnt != '0) && (pending < 3'd2);
        push_ready   = rst_n && (ram_cnt < FULL_CNT) && !(rd_elig && (rr == RD));
        rd_go        = rd_elig && ((rr == RD) || !push_valid);
        wr_go        = push_valid && push_ready && !rd_go;
        rr_next      = rr;
        if (rd_go)      rr_next = WR;
        else if (wr_go) rr_next = RD;
        ram_write_en = wr_go;
        ram_address  = wr_go ? wr_ptr : rd_ptr;
        ram_data_in  = wr_go ? push_data : data_hold;
        level        = (ADDR_W + 2)'(ram_cnt) + (ADDR_W + 2)'(rd_inflight)
                     + (ADDR_W + 2)'(skid_cnt);
    end

    // Arbitration owner register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr <= RD;
        else        rr <= rr_next;
    end

    // Pointers, RAM occupancy, read-in-flight flag and held write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
            data_hold   <= '0;
        end else begin
            rd_inflight <= rd_go;
            if (wr_go) begin
                wr_ptr    <= wr_ptr + 1'b1;
                data_hold <= push_data;
                ram_cnt   <= ram_cnt + 1'b1;
            end
            if (rd_go) begin
                rd_ptr  <= rd_ptr + 1'b1;
                ram_cnt <= ram_cnt - 1'b1;
            end
        end
    end

    ram_fifo_skid #(.DATA_W(DATA_W)) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture      (rd_inflight),
        .capture_data (ram_data_out),
        .pop          (pop_ready),
        .head_data    (pop_data),
        .head_valid   (pop_valid),
        .count        (skid_cnt)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 32-entry RAM model.
module tb_ram_fifo_ctrl;
    import ram_fifo_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int AW = DEF_ADDR_W;

    logic          clk;
    logic          rst_n;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic [AW+1:0] level;
    logic [AW-1:0] ram_address;
    logic          ram_write_en;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    ram_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_data    (push_data),
        .pop_valid    (pop_valid),
        .pop_ready    (pop_ready),
        .pop_data     (pop_data),
        .level        (level),
        .ram_address  (ram_address),
        .ram_write_en (ram_write_en),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous RAM model, read-before-write, one-cycle read latency
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act[63:0], exp[63:0]);
        end
    endtask

    // scoreboard and monitor state
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] wr_addr_q[$];
    int            push_cnt = 0;
    int            pop_cnt  = 0;
    logic [AW-1:0] last_wa  = '0;
    logic [AW-1:0] last_ra  = '0;
    bit            wr_wrap  = 0;
    bit            rd_wrap  = 0;
    bit            alt_chk  = 0;
    logic          prev_we  = 1'b0;
    logic [DW-1:0] last_pop = '0;

    // Monitor at the falling edge: handshakes seen here complete on the next rise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_write_en) begin
                wr_addr_q.push_back(ram_address);
                if (ram_address == '0 && last_wa == AW'(31)) wr_wrap = 1;
                last_wa = ram_address;
            end else begin
                if (ram_address == '0 && last_ra == AW'(31)) rd_wrap = 1;
                last_ra = ram_address;
            end
            if (alt_chk) begin
                check("wr_alternate", DW'(ram_write_en), DW'(!prev_we));
                check("level_le3", DW'(level <= 7'd3), DW'(1));
            end
            prev_we = ram_write_en;
            if (push_valid && push_ready) begin
                exp_q.push_back(push_data);
                push_cnt++;
            end
            if (pop_valid && pop_ready) begin
                if (exp_q.size() > 0) check("pop_order", pop_data, exp_q.pop_front());
                else                  check("pop_extra", DW'(pop_valid), DW'(0));
                last_pop = pop_data;
                pop_cnt++;
            end
        end
    end

    // driver: push n consecutive words base, base+1, ... holding push_valid high
    task automatic push_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            int budget;
            bit acc;
            budget     = 0;
            acc        = 0;
            push_valid = 1'b1;
            push_data  = DW'(base + i);
            while (!acc && budget < 200) begin
                @(negedge clk);
                acc = push_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            check("push_accept", DW'(acc), DW'(1));
        end
        push_valid = 1'b0;
    endtask

    // driver: pop until empty, bounded
    task automatic drain();
        int budget;
        budget    = 0;
        pop_ready = 1'b1;
        while (!(level == '0 && !pop_valid) && budget < 300) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_level", DW'(level), DW'(0));
        check("drain_sb_empty", DW'(exp_q.size()), DW'(0));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit push_done;

    initial begin
        int p0;
        rst_n      = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;
        #1;
        check("rst_push_ready", DW'(push_ready), DW'(0));
        check("rst_pop_valid", DW'(pop_valid), DW'(0));
        check("rst_level", DW'(level), DW'(0));
        check("rst_write_en", DW'(ram_write_en), DW'(0));
        idle(3);
        rst_n = 1'b1;

        // idle after reset
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("idle_push_ready", DW'(push_ready), DW'(1));
            check("idle_pop_valid", DW'(pop_valid), DW'(0));
            check("idle_level", DW'(level), DW'(0));
            check("idle_write_en", DW'(ram_write_en), DW'(0));
        end
        idle(1);

        // three words, consumer stalled
        wr_addr_q.delete();
        push_words(1, 'hA5);
        push_words(1, 'h3C);
        push_words(1, 'h77);
        idle(4);
        check("t2_wr_count", DW'(wr_addr_q.size()), DW'(3));
        for (int k = 0; k < 3; k++) begin
            logic [AW-1:0] a;
            a = (k < wr_addr_q.size()) ? wr_addr_q[k] : AW'(31);
            check("t2_wr_addr", DW'(a), DW'(k));
        end
        check("t2_level", DW'(level), DW'(3));
        check("t2_pop_valid", DW'(pop_valid), DW'(1));
        check("t2_head", pop_data, DW'('hA5));
        drain();
        pop_ready = 1'b0;
        idle(2);

        // fill to capacity
        push_words(34, 0);
        idle(4);
        check("full_level", DW'(level), DW'(34));
        check("full_push_ready", DW'(push_ready), DW'(0));
        check("full_head", pop_data, DW'(0));
        drain();
        pop_ready = 1'b0;
        idle(2);

        // wrap-around with random consumer
        wr_wrap   = 0;
        rd_wrap   = 0;
        p0        = pop_cnt;
        push_done = 0;
        fork
            begin
                push_words(40, 100);
                push_done = 1;
            end
            begin
                int g;
                g = 0;
                while (!push_done && g < 2000) begin
                    @(posedge clk);
                    #1;
                    pop_ready = 1'($urandom_range(0, 1));
                    g++;
                end
            end
        join
        drain();
        check("wrap_pop_count", DW'(pop_cnt - p0), DW'(40));
        check("wrap_wr_ptr", DW'(wr_wrap), DW'(1));
        check("wrap_rd_ptr", DW'(rd_wrap), DW'(1));
        idle(2);

        // continuous push and pop
        p0        = pop_cnt;
        pop_ready = 1'b1;
        fork
            push_words(20, 500);
            begin
                idle(5);
                alt_chk = 1;
                idle(20);
                alt_chk = 0;
            end
        join
        drain();
        check("stream_pop_count", DW'(pop_cnt - p0), DW'(20));
        pop_ready = 1'b0;
        idle(2);

        // reset in the middle of traffic
        push_words(10, 300);
        idle(4);
        check("pre_rst_level", DW'(level), DW'(10));
        rst_n = 1'b0;
        #1;
        check("mid_rst_push_ready", DW'(push_ready), DW'(0));
        check("mid_rst_pop_valid", DW'(pop_valid), DW'(0));
        check("mid_rst_level", DW'(level), DW'(0));
        check("mid_rst_write_en", DW'(ram_write_en), DW'(0));
        check("mid_rst_address", DW'(ram_address), DW'(0));
        check("mid_rst_data_in", ram_data_in, DW'(0));
        check("mid_rst_pop_data", pop_data, DW'(0));
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        p0 = pop_cnt;
        push_words(1, 'hBEEF);
        drain();
        check("post_rst_pops", DW'(pop_cnt - p0), DW'(1));
        check("post_rst_first", last_pop, DW'('hBEEF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
